shared_mem_arbiter: RTL and testbench
=====================================

SHARED_MEM_ARBITER -- requirements
Module: shared_mem_arbiter

Interface
REQ-001 Parameter N_CORES, default 4, number of gpu cores served.
REQ-002 Parameter AW, default 12, shared-memory address width (4096 bytes).
REQ-003 Parameter DW, default 8, data width.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 mem_req_ld  input  N_CORES  per-core load request, level, held until served.
REQ-008 mem_req_st  input  N_CORES  per-core store request, level, held until served.
REQ-009 addr_shared_memory  input  N_CORES*AW  per-core address; core k uses bits [k*AW +: AW].
REQ-010 mem_dat_st  input  N_CORES*DW  per-core store data; core k uses bits [k*DW +: DW].
REQ-011 val_data  output  N_CORES  one-hot per-core completion pulse.
REQ-012 mem_dat  output  DW  load data, broadcast to all cores, valid when any val_data bit is high.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 Storage: internal 2**AW x DW array. Reads and writes are synchronous.
REQ-015 Concurrency: one transaction in flight at a time. All outputs are registered.
REQ-016 FSM states: IDLE, LD, ST_ACK, ST_WR, HOLD.
REQ-017 Arbitration in IDLE: a core is eligible when its ld or st bit is high. Pick the first eligible core at or after rr_ptr, wrapping modulo N_CORES.
REQ-018 Grant latch: on a grant, record the core index g, its address and its request type. rr_ptr <= (g+1) mod N_CORES.
REQ-019 Same-core conflict: if a core raises both ld and st, the load is served and the store stays pending.
REQ-020 Load sequence:
  - Grant at cycle T: IDLE -> LD.
  - LD at T+1: mem_dat <= mem[addr] and val_data[g] <= 1, both visible at T+2.
  - State -> HOLD.
REQ-021 Store sequence:
  - Grant at cycle T: IDLE -> ST_ACK.
  - ST_ACK: val_data[g] <= 1, visible at T+2; state -> ST_WR.
  - ST_WR at T+2: no action, because the core drives its data one cycle after val_data.
  - State -> HOLD.
  - HOLD at T+3: mem[addr] <= mem_dat_st slice g, then -> IDLE.
REQ-022 Store-data timing: the store write happens in HOLD, one cycle after the core has registered its data.
REQ-023 Pulse width: val_data is high for exactly one cycle per transaction; all other bits stay 0.
REQ-024 HOLD: lasts exactly one cycle, then -> IDLE. Core g is excluded from arbitration in the first IDLE cycle after HOLD, because its request drop is registered and lags one cycle.
REQ-025 mem_dat hold: mem_dat holds its last value between loads.
REQ-026 Addressing: the address is used as a full AW-bit index with no wrap or offset logic; address 4095 is legal.
REQ-027 Idle behaviour: with no requests, the FSM stays in IDLE, rr_ptr is unchanged, and there are no writes.
REQ-028 Load/store ordering: a load granted after a store to the same address returns the new data.

Reset
REQ-029 Reset values: state=IDLE, rr_ptr=0, val_data=0, mem_dat=0, busy=0, grant latch cleared.
REQ-030 Reset mid-operation: any in-flight transaction is aborted. No memory write occurs in the reset cycle, and no val_data pulse follows.
REQ-031 Array contents: the memory array is not reset.

Structure
REQ-032 Shared package holds:
  - the FSM state encoding (3-bit constants);
  - default AW/DW;
  - the opcode constants LD=11 and ST=13 used by the cores.
REQ-033 Sub-module: one sub-module, shared_mem_ram (single-port synchronous 2**AW x DW RAM, write-enable, registered read). The arbiter FSM stays in the top module.

Verification
REQ-034 Single store then load:
  - Stimulus: core2 st addr 0x123 data 0xA5 (data driven the cycle after val_data[2]); then core2 ld 0x123.
  - Response: val_data=4'b0100 pulses; mem_dat=0xA5 on the load pulse.
REQ-035 Round-robin:
  - Stimulus: cores 0-3 all assert ld from reset.
  - Response: grants in order 0,1,2,3. Then core0 re-requests together with core3: core0 is served next, since rr_ptr has wrapped to 0.
REQ-036 Load latency:
  - Stimulus: ld asserted at cycle T in IDLE.
  - Response: val_data high at T+2 only; busy high T+1..T+2; FSM back in IDLE by T+3.
REQ-037 Same-core ld and st:
  - Stimulus: core1 raises both to addr 0x010.
  - Response: the load is served first, the store on a later grant; each gets exactly one val_data pulse.
REQ-038 Reset mid-store:
  - Stimulus: reset asserted in ST_WR.
  - Response: val_data=0, state IDLE, mem[addr] unchanged (a later load returns the old value).
REQ-039 Boundary address:
  - Stimulus: st 0xFFF data 0x3C, ld 0xFFF.
  - Response: 0x3C returned; address 0x000 unaffected.

Source files
------------

// File: rtl/shared_mem_arbiter_pkg.sv
// Shared definitions for the GPU-core shared-memory arbiter: FSM encoding,
// default geometry and the load/store opcodes issued by the cores.
package shared_mem_arbiter_pkg;

    localparam int DEF_AW = 12;
    localparam int DEF_DW = 8;

    localparam logic [3:0] OP_LD = 4'd11;
    localparam logic [3:0] OP_ST = 4'd13;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LD     = 3'd1,
        S_ST_ACK = 3'd2,
        S_ST_WR  = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    typedef enum logic {
        REQ_LD = 1'b0,
        REQ_ST = 1'b1
    } req_kind_t;

endpackage

// File: rtl/shared_mem_ram.sv
// Single-port synchronous RAM with write enable and a registered,
// read-enabled output that holds its value between reads.
module shared_mem_ram
    import shared_mem_arbiter_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // NOTE: the array is deliberately left out of reset so it maps onto RAM macros.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset)   rdata <= '0;
        else if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter granting N_CORES load/store requesters one-at-a-time
// access to a shared 2**AW x DW memory.
module shared_mem_arbiter
    import shared_mem_arbiter_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CORES-1:0]    mem_req_ld,
    input  logic [N_CORES-1:0]    mem_req_st,
    input  logic [N_CORES*AW-1:0] addr_shared_memory,
    input  logic [N_CORES*DW-1:0] mem_dat_st,
    output logic [N_CORES-1:0]    val_data,
    output logic [DW-1:0]         mem_dat,
    output logic                  busy
);

    localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    state_t            state, state_nxt;
    logic [IW-1:0]     rr_ptr, g_idx, grant_idx;
    logic [AW-1:0]     g_addr;
    req_kind_t         g_kind;
    logic              grant_vld;
    logic              excl_vld;
    logic [N_CORES-1:0] eligible;
    int                cand;
    logic              ram_we, ram_re;

    // The core just served still shows its request for one cycle after HOLD.
    always_comb begin
        eligible = mem_req_ld | mem_req_st;
        if (excl_vld) eligible[g_idx] = 1'b0;
    end

    // Walk downwards so the candidate closest to rr_ptr is assigned last and wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        grant_vld = 1'b0;
        grant_idx = rr_ptr;
        cand      = 0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            cand = (int'(rr_ptr) + i) % N_CORES;
            if (eligible[cand]) begin
                grant_vld = 1'b1;
                grant_idx = IW'(cand);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (grant_vld) state_nxt = mem_req_ld[grant_idx] ? S_LD : S_ST_ACK;
            S_LD:     state_nxt = S_HOLD;
            S_ST_ACK: state_nxt = S_ST_WR;
            S_ST_WR:  state_nxt = S_HOLD;
            S_HOLD:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is always updated with non-blocking assignments.
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            g_idx    <= '0;
            g_addr   <= '0;
            g_kind   <= REQ_LD;
            val_data <= '0;
            busy     <= 1'b0;
            excl_vld <= 1'b0;
        end else begin
            busy     <= (state_nxt != S_IDLE);
            excl_vld <= (state == S_HOLD);
            val_data <= '0;
            if (state == S_LD || state == S_ST_ACK) val_data[g_idx] <= 1'b1;
            if (state == S_IDLE && grant_vld) begin
                g_idx  <= grant_idx;
                g_addr <= addr_shared_memory[int'(grant_idx)*AW +: AW];
                g_kind <= mem_req_ld[grant_idx] ? REQ_LD : REQ_ST;
                rr_ptr <= IW'((int'(grant_idx) + 1) % N_CORES);
            end
        end
    end

    // Store data is sampled in HOLD, a cycle after the core reacted to val_data.
    assign ram_re = (state == S_LD);
    assign ram_we = (state == S_HOLD) && (g_kind == REQ_ST) && !reset;

    shared_mem_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (g_addr),
        .wdata (mem_dat_st[int'(g_idx)*DW +: DW]),
        .rdata (mem_dat)
    );

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: a table of single-core transactions
// plus hand-written sequences for round-robin, latency, exclusion and reset.
module tb_shared_mem_arbiter;
    import shared_mem_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    ld, st;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] dat_st;
    logic [N-1:0]    val_data;
    logic [DW-1:0]   mem_dat;
    logic            busy;

    always #5 clk = ~clk;

    shared_mem_arbiter #(.N_CORES(N), .AW(AW), .DW(DW)) dut (
        .clk                (clk),
        .reset              (reset),
        .mem_req_ld         (ld),
        .mem_req_st         (st),
        .addr_shared_memory (addr),
        .mem_dat_st         (dat_st),
        .val_data           (val_data),
        .mem_dat            (mem_dat),
        .busy               (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int            core;
        bit            is_st;
        logic [AW-1:0] a;
        logic [DW-1:0] d;   // store data, or expected load data
    } vec_t;

    vec_t vecs[10];

    // One transaction from an otherwise idle arbiter: the core drops its request
    // (and drives store data) the cycle after it sees val_data.
    task automatic txn(input vec_t v);
        int waited = 0;
        addr[v.core*AW +: AW] = v.a;
        if (v.is_st) begin
            dat_st[v.core*DW +: DW] = ~v.d;
            st[v.core] = 1'b1;
        end else begin
            ld[v.core] = 1'b1;
        end
        do begin
            tick();
            waited++;
        end while (val_data == '0 && waited < 20);
        check("txn_latency", waited, 2);
        check("txn_onehot", val_data, 32'd1 << v.core);
        if (!v.is_st) check("txn_load_data", mem_dat, v.d);
        tick();
        if (v.is_st) dat_st[v.core*DW +: DW] = v.d;
        ld[v.core] = 1'b0;
        st[v.core] = 1'b0;
        check("txn_pulse_width", val_data, 0);
        tick();
        tick();
        check("txn_idle_after", busy, 0);
    endtask

    task automatic rr_run(input logic [N-1:0] reqs, input int n_exp, output int ord[4], output int n_got);
        logic [N-1:0] drop = '0;
        n_got = 0;
        ord   = '{-1, -1, -1, -1};
        ld    = reqs;
        for (int c = 0; c < 60 && n_got < n_exp; c++) begin
            tick();
            ld   = ld & ~drop;
            drop = '0;
            if (val_data != '0) begin
                for (int k = 0; k < N; k++)
                    if (val_data[k] && n_got < 4) begin
                        ord[n_got] = k;
                        n_got++;
                    end
                drop = val_data;
            end
        end
        tick();
        ld = ld & ~drop;
        tick();
        tick();
    endtask

    int ord[4];
    int n_got;
    int pulses;
    bit pend_ld, pend_st;
    vec_t v;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2, 1'b1, 12'h123, 8'hA5};
        vecs[1] = '{2, 1'b0, 12'h123, 8'hA5};
        vecs[2] = '{3, 1'b1, 12'h000, 8'h5A};
        vecs[3] = '{0, 1'b1, 12'hFFF, 8'h3C};
        vecs[4] = '{1, 1'b0, 12'hFFF, 8'h3C};
        vecs[5] = '{0, 1'b0, 12'h000, 8'h5A};
        vecs[6] = '{0, 1'b1, 12'h010, 8'h42};
        vecs[7] = '{3, 1'b1, 12'h123, 8'h77};
        vecs[8] = '{1, 1'b0, 12'h123, 8'h77};
        vecs[9] = '{2, 1'b0, 12'h000, 8'h5A};

        reset  = 1'b1;
        ld     = '0;
        st     = '0;
        addr   = {N{12'h123}};
        dat_st = '0;
        tick();
        tick();
        tick();
        reset = 1'b0;
        check("reset_val_data", val_data, 0);
        check("reset_mem_dat", mem_dat, 0);
        check("reset_busy", busy, 0);

        // No requests: nothing happens.
        for (int i = 0; i < 4; i++) tick();
        check("idle_busy", busy, 0);
        check("idle_val_data", val_data, 0);

        // All four cores request loads straight out of reset.
        rr_run(4'b1111, 4, ord, n_got);
        check("rr_count", n_got, 4);
        for (int i = 0; i < 4; i++) check("rr_order", ord[i], i);
        // rr_ptr has wrapped to 0, so core0 beats core3.
        rr_run(4'b1001, 2, ord, n_got);
        check("rr_wrap_count", n_got, 2);
        check("rr_wrap_first", ord[0], 0);
        check("rr_wrap_second", ord[1], 3);

        for (int i = 0; i < 10; i++) txn(vecs[i]);

        // Load latency, cycle by cycle.
        addr[0*AW +: AW] = 12'h123;
        ld[0] = 1'b1;
        tick();
        check("lat_t1_busy", busy, 1);
        check("lat_t1_val", val_data, 0);
        tick();
        check("lat_t2_busy", busy, 1);
        check("lat_t2_val", val_data, 4'b0001);
        check("lat_t2_data", mem_dat, 8'h77);
        ld[0] = 1'b0;
        tick();
        check("lat_t3_busy", busy, 0);
        check("lat_t3_val", val_data, 0);
        tick();
        check("hold_mem_dat", mem_dat, 8'h77);

        // Core1 holds its request one cycle too long; it must not be re-served.
        addr[1*AW +: AW] = 12'h000;
        ld[1] = 1'b1;
        tick();
        tick();
        check("excl_first_pulse", val_data, 4'b0010);
        tick();
        tick();
        ld[1] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (val_data != '0) pulses++;
        end
        check("excl_no_regrant", pulses, 0);

        // Same-core ld + st: load first (old 0x42), then the store of 0x99.
        addr[1*AW +: AW]   = 12'h010;
        dat_st[1*DW +: DW] = 8'h00;
        ld[1]   = 1'b1;
        st[1]   = 1'b1;
        pulses  = 0;
        pend_ld = 1'b0;
        pend_st = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (pend_ld) ld[1] = 1'b0;
            if (pend_st) begin
                dat_st[1*DW +: DW] = 8'h99;
                st[1] = 1'b0;
            end
            pend_ld = 1'b0;
            pend_st = 1'b0;
            if (val_data != '0) begin
                pulses++;
                check("both_onehot", val_data, 4'b0010);
                if (pulses == 1) begin
                    check("both_load_first", mem_dat, 8'h42);
                    pend_ld = 1'b1;
                end else begin
                    pend_st = 1'b1;
                end
            end
        end
        check("both_pulses", pulses, 2);
        v = '{1, 1'b0, 12'h010, 8'h99};
        txn(v);

        // Reset while in ST_WR: no write, no pulse afterwards.
        addr[2*AW +: AW] = 12'h123;
        dat_st[2*DW +: DW] = 8'hDE;
        st[2] = 1'b1;
        tick();
        tick();
        check("rst_st_pulse", val_data, 4'b0100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        st[2] = 1'b0;
        check("rst_val_data", val_data, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_dat", mem_dat, 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (val_data != '0) pulses++;
        end
        check("rst_no_pulse", pulses, 0);
        v = '{2, 1'b0, 12'h123, 8'h77};
        txn(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
